fir_sample_feeder: RTL and testbench

Upstream stage of the 64-tap FIR controller. Buffers incoming samples in a small FIFO with a valid/ready handshake. Issues one sample at a time to the FIR with a single-cycle `fir_input_valid` pulse, then holds off until the FIR signals `fir_output_valid`. A watchdog and sticky error flags catch a stalled or misbehaving FIR.

---
 rtl/fir_sample_feeder_if.sv | 31 +++
 rtl/fir_sample_feeder.sv | 119 +++++++++++
 tb/tb_fir_sample_feeder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_feeder_if.sv
// Handshake bundle between the sample source, the feeder and the FIR core.
// The slave modport is the feeder's view; master is the surrounding logic's view.
interface fir_sample_feeder_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] fir_data;
    logic              fir_input_valid;
    logic              fir_output_valid;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              timeout_err;
    logic              spurious_err;

    modport slave (
        input  s_data, s_valid, fir_output_valid,
        output s_ready, fir_data, fir_input_valid, busy, count,
               timeout_err, spurious_err
    );

    modport master (
        output s_data, s_valid, fir_output_valid,
        input  s_ready, fir_data, fir_input_valid, busy, count,
               timeout_err, spurious_err
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// Sample FIFO in front of the FIR core: issues one sample per FIR run and
// waits for completion, with a saturating watchdog and sticky error flags.
module fir_sample_feeder #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_sample_feeder_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [DATA_W-1:0] fir_data_q, fir_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic              spurious_err_q, spurious_err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              s_ready;
    logic              push;
    logic              pop;

    // Full blocks the push even when a pop happens in the same cycle.
    assign s_ready = (count_q != CNT_W'(DEPTH));
    assign push    = bus.s_valid && s_ready;
    assign pop     = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        wdog_d         = wdog_q;
        fir_data_d     = fir_data_q;
        timeout_err_d  = timeout_err_q;
        spurious_err_d = spurious_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            fir_data_d = mem[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (bus.fir_output_valid) spurious_err_d = 1'b1;
                if (pop) state_d = ISSUE;
            end
            ISSUE: begin
                if (bus.fir_output_valid) spurious_err_d = 1'b1;
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion wins over an abort landing in the same cycle.
                if (bus.fir_output_valid) begin
                    state_d = IDLE;
                end else if (wdog_q == WD_W'(TIMEOUT)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            wdog_q         <= '0;
            fir_data_q     <= '0;
            timeout_err_q  <= 1'b0;
            spurious_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            wdog_q         <= wdog_d;
            fir_data_q     <= fir_data_d;
            timeout_err_q  <= timeout_err_d;
            spurious_err_q <= spurious_err_d;
        end
    end

    // Storage array carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.s_data;
    end

    assign bus.s_ready         = s_ready;
    assign bus.fir_data        = fir_data_q;
    assign bus.fir_input_valid = (state_q == ISSUE);
    assign bus.busy            = (state_q != IDLE);
    assign bus.count           = count_q;
    assign bus.timeout_err     = timeout_err_q;
    assign bus.spurious_err    = spurious_err_q;
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Random and directed stimulus for fir_sample_feeder, compared every cycle
// against a queue-based model of the feeder's behaviour.
module tb_fir_sample_feeder;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_sample_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fir_sample_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of stored samples, plus where the current FIR job stands.
    logic [DATA_W-1:0] m_q[$];
    int                m_phase;   // 0 no job, 1 start pulse cycle, 2 FIR running
    int                m_waited;  // FIR-running cycles already elapsed without completion
    logic [DATA_W-1:0] m_data;
    bit                m_terr;
    bit                m_serr;

    logic [DATA_W-1:0] p_q[$];    // samples the source still wants to send

    function automatic void model_reset();
        m_q.delete();
        m_phase  = 0;
        m_waited = 0;
        m_data   = '0;
        m_terr   = 1'b0;
        m_serr   = 1'b0;
    endfunction

    function automatic void model_step(bit sv, logic [DATA_W-1:0] sd, bit fov);
        bit accept;
        accept = sv && (m_q.size() < DEPTH);
        if (m_phase == 0) begin
            if (fov) m_serr = 1'b1;
            if (m_q.size() > 0) begin
                m_data  = m_q.pop_front();
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (fov) m_serr = 1'b1;
            m_phase  = 2;
            m_waited = 0;
        end else begin
            if (fov) m_phase = 0;
            else if (m_waited == TIMEOUT) begin
                m_phase = 0;
                m_terr  = 1'b1;
            end else m_waited++;
        end
        if (accept) m_q.push_back(sd);
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_model();
        chk("s_ready",         32'(bus.s_ready),         32'(m_q.size() < DEPTH));
        chk("count",           32'(bus.count),           32'(m_q.size()));
        chk("fir_input_valid", 32'(bus.fir_input_valid), 32'(m_phase == 1));
        chk("busy",            32'(bus.busy),            32'(m_phase != 0));
        chk("fir_data",        32'(bus.fir_data),        32'(m_data));
        chk("timeout_err",     32'(bus.timeout_err),     32'(m_terr));
        chk("spurious_err",    32'(bus.spurious_err),    32'(m_serr));
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance model, pass the edge.
    task automatic step(input bit fov);
        bit                sv;
        bit                rdy;
        logic [DATA_W-1:0] sd;
        sv  = (p_q.size() > 0);
        sd  = sv ? p_q[0] : '0;
        bus.s_valid          = sv;
        bus.s_data           = sd;
        bus.fir_output_valid = fov;
        @(negedge clk);
        compare_model();
        rdy = bus.s_ready;
        if (!rst) model_step(sv, sd, fov);
        @(posedge clk);
        #1;
        if (sv && rdy) void'(p_q.pop_front());
    endtask

    initial begin
        bus.s_valid          = 1'b0;
        bus.s_data           = '0;
        bus.fir_output_valid = 1'b0;
        model_reset();
        repeat (3) step(1'b0);
        rst = 1'b0;
        chk("rst_count",   32'(bus.count),   32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_fiv",     32'(bus.fir_input_valid), 32'd0);

        // Single sample: start pulse two edges after acceptance, FIR done 67 cycles later.
        p_q.push_back(16'h1234);
        step(1'b0);
        step(1'b0);
        chk("one_fiv",  32'(bus.fir_input_valid), 32'd1);
        chk("one_data", 32'(bus.fir_data),        32'h1234);
        repeat (67) step(1'b0);
        chk("one_busy_held", 32'(bus.busy), 32'd1);
        step(1'b1);
        chk("one_busy_fall", 32'(bus.busy), 32'd0);

        // Back-to-back burst with FIR stalled: FIFO fills and back-pressures.
        for (int i = 0; i < 10; i++) p_q.push_back(16'hA000 + 16'(i));
        repeat (12) step(1'b0);
        chk("full_count",   32'(bus.count),   32'd8);
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        chk("full_held",    32'(p_q.size()),  32'd1);
        step(1'b1);
        step(1'b0);
        chk("pop_no_push",  32'(bus.count),   32'd7);
        chk("pop_fiv",      32'(bus.fir_input_valid), 32'd1);
        chk("pop_data",     32'(bus.fir_data), 32'hA001);
        step(1'b0);
        chk("push_after",   32'(bus.count),   32'd8);

        // Random traffic with randomly delayed FIR completion.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 1 && p_q.size() < 4)
                p_q.push_back(DATA_W'($urandom_range(0, 65535)));
            step(m_phase == 2 && $urandom_range(0, 15) == 0);
        end
        for (int n = 0; n < 60; n++) step(m_phase == 2);
        chk("drained", 32'(bus.count), 32'd0);

        // Completion in the same cycle the watchdog reaches its limit.
        p_q.push_back(16'h5A5A);
        repeat (3) step(1'b0);
        repeat (255) step(1'b0);
        chk("tie_busy", 32'(bus.busy), 32'd1);
        step(1'b1);
        chk("tie_no_err", 32'(bus.timeout_err), 32'd0);
        chk("tie_idle",   32'(bus.busy),        32'd0);

        // FIR never answers: abort, then the next queued sample issues.
        p_q.push_back(16'hBEEF);
        p_q.push_back(16'hCAFE);
        repeat (3) step(1'b0);
        repeat (255) step(1'b0);
        chk("to_before", 32'(bus.timeout_err), 32'd0);
        step(1'b0);
        chk("to_set",    32'(bus.timeout_err), 32'd1);
        chk("to_idle",   32'(bus.busy),        32'd0);
        step(1'b0);
        chk("to_next_fiv",  32'(bus.fir_input_valid), 32'd1);
        chk("to_next_data", 32'(bus.fir_data),        32'hCAFE);
        step(1'b0);
        step(1'b1);

        // Reset mid-WAIT with samples queued; the late completion is spurious.
        for (int i = 0; i < 4; i++) p_q.push_back(16'h7000 + 16'(i));
        repeat (6) step(1'b0);
        chk("rw_queued", 32'(bus.count), 32'd3);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rw_count", 32'(bus.count), 32'd0);
        chk("rw_busy",  32'(bus.busy),  32'd0);
        step(1'b0);
        rst = 1'b0;
        step(1'b0);
        step(1'b1);
        chk("rw_spurious", 32'(bus.spurious_err),    32'd1);
        chk("rw_no_fiv",   32'(bus.fir_input_valid), 32'd0);
        chk("rw_count2",   32'(bus.count),           32'd0);
        step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
